sram_1rw1r_port_arbiter: RTL
============================

// Module: sram_1rw1r_port_arbiter
// PURPOSE
//  Shares a 1RW+1R OpenRAM macro (sky130, 32x256, byte write mask) among three clients.
//  Two RW clients (e.g. vector lane / DMA) are round-robin arbitrated onto port 0.
//  One read-only client owns port 1.
//  All SRAM pins are driven from registers; read data returns on fixed-latency response strobes.
//  Sits between vector-processor datapath clients and the SRAM top wrapper.
// PARAMETERS
//  DATA_WIDTH  32  word width; matches macro
//  ADDR_WIDTH  8   address width; 256 words
//  NUM_WMASKS  4   byte-lane write mask width (DATA_WIDTH/8)
//  RD_LATENCY  1   cycles from SRAM capture edge to dout usable; legal range 1..3
// PORTS
//  clk            in   1     single clock; also drives macro clk0 and clk1
//  rst_n          in   1     async active-low reset
//  reqN_valid     in   1     N=0,1: RW client request valid
//  reqN_ready     out  1     N=0,1: request accepted this cycle
//  reqN_we        in   1     1=write, 0=read
//  reqN_wmask     in   NUM_WMASKS  byte enables; ignored for reads
//  reqN_addr      in   ADDR_WIDTH  word address
//  reqN_wdata     in   DATA_WIDTH  write data
//  rspN_valid     out  1     one-cycle strobe: read data for client N
//  rspN_rdata     out  DATA_WIDTH  read data; held until next strobe
//  rd_valid       in   1     port-1 read client request
//  rd_ready       out  1     port-1 accept
//  rd_addr        in   ADDR_WIDTH  port-1 address
//  rd_rsp_valid   out  1     port-1 read data strobe
//  rd_rsp_rdata   out  DATA_WIDTH  port-1 read data
//  sram_csb0/web0/wmask0/addr0/din0  out  1/1/NUM_WMASKS/ADDR_WIDTH/DATA_WIDTH  registered port-0 pins
//  sram_dout0     in   DATA_WIDTH  port-0 read data
//  sram_csb1/addr1  out  1/ADDR_WIDTH  registered port-1 pins
//  sram_dout1     in   DATA_WIDTH  port-1 read data
// BEHAVIOUR
//  Reset (async assert, sync-style deassert at next edge):
//   - csb0=csb1=web0=1; wmask0, addr0, din0, addr1 = 0.
//   - All rsp*_valid = 0; rdata = 0; RR pointer = "client 1 last".
//   - In-flight reads are discarded; no response for them after reset.
//  Arbitration, port 0, combinational grant:
//   - Only one valid -> it is granted.
//   - Both valid -> the client not granted last wins; the pointer updates only on a grant.
//   - reqN_ready = grant. Handshake = valid & ready.
//   - Continuously-valid client is granted within 2 cycles.
//   - Ready never depends on ready; valid/payload must hold until accepted.
//  Issue: accept at edge E0 -> pins registered at E0 with csb0=0, web0=~we, wmask0, addr0, din0.
//   - Macro captures at E1. Idle cycle: csb0=1; other pins hold previous values.
//  Read return:
//   - Controller registers sram_dout0 at edge E(1+RD_LATENCY).
//   - rspN_valid is high for exactly the following cycle.
//   - Total latency accept -> strobe = RD_LATENCY+1 cycles (2 at default).
//   - A (RD_LATENCY+1)-deep shift register of {valid,client_id} tracks the owner.
//   - Fully pipelined: one new request per cycle; back-to-back reads give back-to-back strobes.
//  Writes: no response; visible to any read accepted on a later cycle.
//  Port 1: rd_ready=1 except hazard, below; same register/latency scheme.
//  Hazard: a port-1 read to an address being written on port 0 in the same cycle is not allowed.
//   - rd_ready=0 when a port-0 write to rd_addr is accepted this cycle.
//   - The read issues next cycle and returns the new data.
//  Responses have no backpressure; clients must sink every strobe.
//  Addresses wrap naturally at ADDR_WIDTH; no range check.
// TESTING
//  1. Reset; write 0xDEADBEEF @0x10 (mask 4'hF) via client 0, then read @0x10.
//     -> rsp0_valid exactly 2 cycles after read accept, rdata=0xDEADBEEF.
//  2. Both clients valid every cycle, distinct reads.
//     -> grants alternate 0,1,0,1...; each rsp routes to its issuer in order.
//  3. Write 0xFFFFFFFF @5, then write 0x00000000 mask 4'b0101, read @5 -> 0xFF00FF00.
//  4. Client 0 writes 0x1234 @7 while rd_addr=7 same cycle.
//     -> rd_ready=0 that cycle; next-cycle read returns 0x1234 on rd_rsp.
//  5. Assert rst_n low with two reads in flight.
//     -> no rsp strobes; csb0=csb1=1 immediately; traffic resumes after release.
//  6. Streaming reads 0..255 on port 1, RD_LATENCY=1 and 3.
//     -> 256 consecutive strobes, data matching preload, addr wraps 255->0.

Source files
------------

// File: rtl/sram_1rw1r_port_arbiter.sv
// Three-client front end for a 1RW+1R SRAM macro: two round-robin RW clients on port 0,
// one read-only client on port 1, registered macro pins and fixed-latency read strobes.
module sram_1rw1r_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // RW client 0
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [NUM_WMASKS-1:0] req0_wmask,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  // RW client 1
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [NUM_WMASKS-1:0] req1_wmask,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  // read-only client on port 1
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] rd_rsp_rdata,
  // macro port 0
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  // macro port 1
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int DEPTH = RD_LATENCY + 1;

  logic                  last_q, last_d;
  logic                  gnt0, gnt1, p0_acc, p1_acc, wr_hazard;
  logic                  acc_we;
  logic [NUM_WMASKS-1:0] acc_wmask;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;

  logic                  csb0_q, csb0_d, web0_q, web0_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic                  csb1_q, csb1_d;
  logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;

  logic [DEPTH-1:0]      p0_vld_q, p0_vld_d, p0_id_q, p0_id_d, p1_vld_q, p1_vld_d;
  logic                  rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic                  rd_rsp_valid_q, rd_rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d, rsp1_rdata_q, rsp1_rdata_d;
  logic [DATA_WIDTH-1:0] rd_rsp_rdata_q, rd_rsp_rdata_d;

  // last_q = 1 means client 1 won the most recent arbitration
  always_comb begin
    gnt0      = req0_valid & (~req1_valid | last_q);
    gnt1      = req1_valid & (~req0_valid | ~last_q);
    p0_acc    = gnt0 | gnt1;
    last_d    = p0_acc ? gnt1 : last_q;
    acc_we    = gnt1 ? req1_we    : req0_we;
    acc_wmask = gnt1 ? req1_wmask : req0_wmask;
    acc_addr  = gnt1 ? req1_addr  : req0_addr;
    acc_wdata = gnt1 ? req1_wdata : req0_wdata;
    // port-1 read stalls one cycle behind a same-address write so it sees the new word
    wr_hazard = p0_acc & acc_we & (acc_addr == rd_addr);
    p1_acc    = rd_valid & ~wr_hazard;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rd_ready   = ~wr_hazard;

  always_comb begin
    csb0_d   = ~p0_acc;
    web0_d   = web0_q;
    wmask0_d = wmask0_q;
    addr0_d  = addr0_q;
    din0_d   = din0_q;
    if (p0_acc) begin
      web0_d   = ~acc_we;
      wmask0_d = acc_wmask;
      addr0_d  = acc_addr;
      din0_d   = acc_wdata;
    end
    csb1_d  = ~p1_acc;
    addr1_d = p1_acc ? rd_addr : addr1_q;
  end

  // Ownership pipeline: stage RD_LATENCY lines up with usable macro dout
  always_comb begin
    p0_vld_d       = {p0_vld_q[DEPTH-2:0], p0_acc & ~acc_we};
    p0_id_d        = {p0_id_q[DEPTH-2:0], gnt1};
    p1_vld_d       = {p1_vld_q[DEPTH-2:0], p1_acc};
    rsp0_valid_d   = p0_vld_q[RD_LATENCY] & ~p0_id_q[RD_LATENCY];
    rsp1_valid_d   = p0_vld_q[RD_LATENCY] &  p0_id_q[RD_LATENCY];
    rd_rsp_valid_d = p1_vld_q[RD_LATENCY];
    rsp0_rdata_d   = rsp0_valid_d   ? sram_dout0 : rsp0_rdata_q;
    rsp1_rdata_d   = rsp1_valid_d   ? sram_dout0 : rsp1_rdata_q;
    rd_rsp_rdata_d = rd_rsp_valid_d ? sram_dout1 : rd_rsp_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q         <= 1'b1;
      csb0_q         <= 1'b1;
      web0_q         <= 1'b1;
      wmask0_q       <= '0;
      addr0_q        <= '0;
      din0_q         <= '0;
      csb1_q         <= 1'b1;
      addr1_q        <= '0;
      p0_vld_q       <= '0;
      p0_id_q        <= '0;
      p1_vld_q       <= '0;
      rsp0_valid_q   <= 1'b0;
      rsp1_valid_q   <= 1'b0;
      rd_rsp_valid_q <= 1'b0;
      rsp0_rdata_q   <= '0;
      rsp1_rdata_q   <= '0;
      rd_rsp_rdata_q <= '0;
    end else begin
      last_q         <= last_d;
      csb0_q         <= csb0_d;
      web0_q         <= web0_d;
      wmask0_q       <= wmask0_d;
      addr0_q        <= addr0_d;
      din0_q         <= din0_d;
      csb1_q         <= csb1_d;
      addr1_q        <= addr1_d;
      p0_vld_q       <= p0_vld_d;
      p0_id_q        <= p0_id_d;
      p1_vld_q       <= p1_vld_d;
      rsp0_valid_q   <= rsp0_valid_d;
      rsp1_valid_q   <= rsp1_valid_d;
      rd_rsp_valid_q <= rd_rsp_valid_d;
      rsp0_rdata_q   <= rsp0_rdata_d;
      rsp1_rdata_q   <= rsp1_rdata_d;
      rd_rsp_rdata_q <= rd_rsp_rdata_d;
    end
  end

  assign sram_csb0    = csb0_q;
  assign sram_web0    = web0_q;
  assign sram_wmask0  = wmask0_q;
  assign sram_addr0   = addr0_q;
  assign sram_din0    = din0_q;
  assign sram_csb1    = csb1_q;
  assign sram_addr1   = addr1_q;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rd_rsp_valid = rd_rsp_valid_q;
  assign rsp0_rdata   = rsp0_rdata_q;
  assign rsp1_rdata   = rsp1_rdata_q;
  assign rd_rsp_rdata = rd_rsp_rdata_q;

endmodule
